// File: rtl/tdc_daq_pkg.sv
// tdc_daq_pkg
//   Shared definitions for the TDC DAQ window collector: record field widths,
//   output word layout, header FIFO entry format and output FSM states.
//   Output words:
//     header = {1'b1, ovf, 10'd0, tag[3:0], 8'd0, count[7:0]}  (tag in [19:16])
//     hit    = {1'b0, 9'd0, tdc[21:0]}
package tdc_daq_pkg;

  localparam int TAG_W  = 4;
  localparam int TDC_W  = 22;
  localparam int CNT_W  = 8;
  localparam int REC_W  = TAG_W + TDC_W;
  localparam int WORD_W = 32;
  localparam int HDR_W  = 1 + TAG_W + CNT_W;

  localparam int MARK_BIT = 31;
  localparam int OVF_BIT  = 30;
  localparam int TAG_LSB  = 16;
  localparam int CNT_LSB  = 0;
  localparam int TDC_LSB  = 0;

  localparam logic MARK_HDR = 1'b1;
  localparam logic MARK_HIT = 1'b0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] cnt;
  } hdr_t;

  typedef enum logic [1:0] {
    OUT_IDLE  = 2'd0,
    OUT_HDR   = 2'd1,
    OUT_DRAIN = 2'd2
  } out_state_t;

  function automatic logic [WORD_W-1:0] hdr_word(input hdr_t h);
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[MARK_BIT]          = MARK_HDR;
    w[OVF_BIT]           = h.ovf;
    w[TAG_LSB +: TAG_W]  = h.tag;
    w[CNT_LSB +: CNT_W]  = h.cnt;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] hit_word(input logic [TDC_W-1:0] tdc);
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[MARK_BIT]          = MARK_HIT;
    w[TDC_LSB +: TDC_W]  = tdc;
    return w;
  endfunction

endpackage

// File: rtl/tdc_daq_sync_fifo.sv
// tdc_daq_sync_fifo
//   Single-clock first-word-fall-through FIFO. rdata shows the head entry
//   whenever empty is low. Push while full is accepted only if a pop happens
//   in the same cycle.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   push, wdata   write request and data
//   pop, rdata    read request and head data
//   full, empty   status
//   level         number of stored entries (0..DEPTH)
module tdc_daq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tdc_daq_window_collector.sv
// tdc_daq_window_collector
//   Groups TDC hit records into trigger windows by tag and streams each
//   closed window as one header word followed by its hit words.
// Ports
//   rio_phy_clk, rio_phy_rst_n   clock, asynchronous active-low reset
//   rtlink_stb_i, rtlink_data_i  record strobe and {tag[3:0], tdc[21:0]}
//   out_valid_o, out_ready_i     32-bit output stream handshake
//   out_data_o                   header or hit word
//   lost_windows_o               windows discarded for lack of a header slot
//   dropped_hits_o               hits dropped (FIFO full or count at max)
//
// Output FSM
//   state     | meaning
//   OUT_IDLE  | nothing presented, waiting for a queued header
//   OUT_HDR   | header word presented; header popped on handshake
//   OUT_DRAIN | hit word presented; rem_q words left including this one
module tdc_daq_window_collector
  import tdc_daq_pkg::*;
#(
  parameter int HIT_DEPTH = 256,
  parameter int HDR_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              rio_phy_clk,
  input  logic              rio_phy_rst_n,
  input  logic              rtlink_stb_i,
  input  logic [REC_W-1:0]  rtlink_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic [15:0]       lost_windows_o,
  output logic [15:0]       dropped_hits_o
);

  localparam int                HL_W       = $clog2(HDR_DEPTH) + 1;
  localparam logic [HL_W:0]     HDR_LIM    = (HL_W+1)'(HDR_DEPTH);
  localparam logic [15:0]       TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [TAG_W-1:0] rec_tag;
  logic [TDC_W-1:0] rec_tdc;
  assign rec_tag = rtlink_data_i[REC_W-1 -: TAG_W];
  assign rec_tdc = rtlink_data_i[TDC_W-1:0];

  // FIFO interfaces
  logic                       hit_push, hit_pop, hit_full, hit_empty;
  logic [TDC_W-1:0]           hit_rdata;
  logic [$clog2(HIT_DEPTH):0] hit_level;
  logic                       hdr_push, hdr_pop, hdr_full, hdr_empty;
  hdr_t                       hdr_wdata, hdr_rdata;
  logic [HL_W-1:0]            hdr_level;
  logic                       unused_fifo_status;

  assign unused_fifo_status = ^{hdr_full, hit_level, hit_empty};

  tdc_daq_sync_fifo #(.WIDTH(TDC_W), .DEPTH(HIT_DEPTH)) u_hit_fifo (
    .clk   (rio_phy_clk),
    .rst_n (rio_phy_rst_n),
    .push  (hit_push),
    .wdata (rec_tdc),
    .pop   (hit_pop),
    .rdata (hit_rdata),
    .full  (hit_full),
    .empty (hit_empty),
    .level (hit_level)
  );

  tdc_daq_sync_fifo #(.WIDTH(HDR_W), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk   (rio_phy_clk),
    .rst_n (rio_phy_rst_n),
    .push  (hdr_push),
    .wdata (hdr_wdata),
    .pop   (hdr_pop),
    .rdata (hdr_rdata),
    .full  (hdr_full),
    .empty (hdr_empty),
    .level (hdr_level)
  );

  // ---------------------------------------------------------------- collector
  // A "lost" window owns no header slot: it only tracks tag/idle so that its
  // remaining records are swallowed until a tag change or timeout.
  logic             win_open_q, win_open_d;
  logic             win_lost_q, win_lost_d;
  logic             win_ovf_q,  win_ovf_d;
  logic [TAG_W-1:0] win_tag_q,  win_tag_d;
  logic [CNT_W-1:0] win_cnt_q,  win_cnt_d;
  logic [15:0]      idle_q,     idle_d;
  logic             do_open;
  logic             lost_inc, drop_inc;

  assign hdr_wdata = '{ovf: win_ovf_q, tag: win_tag_q, cnt: win_cnt_q};

  always_comb begin
    win_open_d = win_open_q;
    win_lost_d = win_lost_q;
    win_ovf_d  = win_ovf_q;
    win_tag_d  = win_tag_q;
    win_cnt_d  = win_cnt_q;
    idle_d     = idle_q;
    hit_push   = 1'b0;
    hdr_push   = 1'b0;
    do_open    = 1'b0;
    lost_inc   = 1'b0;
    drop_inc   = 1'b0;

    if (win_open_q) begin
      if (rtlink_stb_i && (rec_tag == win_tag_q)) begin
        idle_d = '0;
        if (!win_lost_q) begin
          if (!hit_full && (win_cnt_q != CNT_MAX)) begin
            hit_push  = 1'b1;
            win_cnt_d = win_cnt_q + 1'b1;
          end else begin
            win_ovf_d = 1'b1;
            drop_inc  = 1'b1;
          end
        end
      end else if (rtlink_stb_i) begin
        hdr_push = !win_lost_q;
        do_open  = 1'b1;
      end else if (idle_q == TIMEOUT_M1) begin
        hdr_push   = !win_lost_q;
        win_open_d = 1'b0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else if (rtlink_stb_i) begin
      do_open = 1'b1;
    end

    // A header pushed this cycle by the closing window already occupies its
    // slot, so it is counted against the new reservation.
    if (do_open) begin
      win_open_d = 1'b1;
      win_tag_d  = rec_tag;
      idle_d     = '0;
      win_cnt_d  = '0;
      win_ovf_d  = 1'b0;
      if (({1'b0, hdr_level} + {{HL_W{1'b0}}, hdr_push}) < HDR_LIM) begin
        win_lost_d = 1'b0;
        if (!hit_full) begin
          hit_push  = 1'b1;
          win_cnt_d = CNT_ONE;
        end else begin
          win_ovf_d = 1'b1;
          drop_inc  = 1'b1;
        end
      end else begin
        win_lost_d = 1'b1;
        lost_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge rio_phy_clk or negedge rio_phy_rst_n) begin
    if (!rio_phy_rst_n) begin
      win_open_q     <= 1'b0;
      win_lost_q     <= 1'b0;
      win_ovf_q      <= 1'b0;
      win_tag_q      <= '0;
      win_cnt_q      <= '0;
      idle_q         <= '0;
      lost_windows_o <= '0;
      dropped_hits_o <= '0;
    end else begin
      win_open_q <= win_open_d;
      win_lost_q <= win_lost_d;
      win_ovf_q  <= win_ovf_d;
      win_tag_q  <= win_tag_d;
      win_cnt_q  <= win_cnt_d;
      idle_q     <= idle_d;
      if (lost_inc && (lost_windows_o != 16'hFFFF)) lost_windows_o <= lost_windows_o + 1'b1;
      if (drop_inc && (dropped_hits_o != 16'hFFFF)) dropped_hits_o <= dropped_hits_o + 1'b1;
    end
  end

  // --------------------------------------------------------------- output FSM
  // Hit words are popped as they are loaded into the output register; the
  // header stays in its FIFO until accepted so it keeps holding its slot.
  out_state_t       out_state_q, out_state_d;
  logic             out_valid_d;
  logic [WORD_W-1:0] out_data_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  always_comb begin
    out_state_d = out_state_q;
    out_valid_d = out_valid_o;
    out_data_d  = out_data_o;
    rem_d       = rem_q;
    hdr_pop     = 1'b0;
    hit_pop     = 1'b0;

    unique case (out_state_q)
      OUT_IDLE: begin
        if (!hdr_empty) begin
          out_state_d = OUT_HDR;
          out_valid_d = 1'b1;
          out_data_d  = hdr_word(hdr_rdata);
          rem_d       = hdr_rdata.cnt;
        end
      end
      OUT_HDR: begin
        if (out_ready_i) begin
          hdr_pop = 1'b1;
          if (rem_q != '0) begin
            out_state_d = OUT_DRAIN;
            out_data_d  = hit_word(hit_rdata);
            hit_pop     = 1'b1;
          end else begin
            out_state_d = OUT_IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      OUT_DRAIN: begin
        if (out_ready_i) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_ONE) begin
            out_state_d = OUT_IDLE;
            out_valid_d = 1'b0;
          end else begin
            out_data_d = hit_word(hit_rdata);
            hit_pop    = 1'b1;
          end
        end
      end
      default: begin
        out_state_d = OUT_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rio_phy_clk or negedge rio_phy_rst_n) begin
    if (!rio_phy_rst_n) begin
      out_state_q <= OUT_IDLE;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      rem_q       <= '0;
    end else begin
      out_state_q <= out_state_d;
      out_valid_o <= out_valid_d;
      out_data_o  <= out_data_d;
      rem_q       <= rem_d;
    end
  end

endmodule

// File: tb/tb_tdc_daq_window_collector.sv
module tb_tdc_daq_window_collector;

  localparam int TIMEOUT = 16;
  localparam int DRAIN_BOUND = 1500;

  logic        rio_phy_clk = 1'b0;
  logic        rio_phy_rst_n = 1'b0;
  logic        rtlink_stb_i = 1'b0;
  logic [25:0] rtlink_data_i = '0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic [15:0] lost_windows_o;
  logic [15:0] dropped_hits_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  bit          rand_ready = 1'b0;

  tdc_daq_window_collector #(
    .HIT_DEPTH (256),
    .HDR_DEPTH (4),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .rio_phy_clk    (rio_phy_clk),
    .rio_phy_rst_n  (rio_phy_rst_n),
    .rtlink_stb_i   (rtlink_stb_i),
    .rtlink_data_i  (rtlink_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .lost_windows_o (lost_windows_o),
    .dropped_hits_o (dropped_hits_o)
  );

  always #5 rio_phy_clk = ~rio_phy_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input bit ovf, input logic [3:0] tag, input logic [7:0] cnt);
    return {1'b1, ovf, 10'd0, tag, 8'd0, cnt};
  endfunction

  function automatic logic [31:0] mk_hit(input logic [21:0] tdc);
    return {10'd0, tdc};
  endfunction

  // scoreboard + stall stability monitor
  logic        stall_q = 1'b0;
  logic [31:0] stall_data = '0;
  always @(negedge rio_phy_clk) begin
    if (!rio_phy_rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check_val("stall_valid", {31'd0, out_valid_o}, 32'd1);
        check_val("stall_data", out_data_o, stall_data);
      end
      if (out_valid_o && out_ready_i) begin
        check_val("sb_has_exp", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) check_val("sb_word", out_data_o, exp_q.pop_front());
      end
      stall_q    = out_valid_o && !out_ready_i;
      stall_data = out_data_o;
    end
  end

  always @(posedge rio_phy_clk) begin
    if (rand_ready) begin
      #1;
      out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic drive_rec(input logic [3:0] tag, input logic [21:0] tdc);
    rtlink_stb_i  = 1'b1;
    rtlink_data_i = {tag, tdc};
    @(posedge rio_phy_clk); #1;
    rtlink_stb_i  = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    rtlink_stb_i = 1'b0;
    repeat (n) @(posedge rio_phy_clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    rand_ready = 1'b0;
    @(posedge rio_phy_clk); #1;
    out_ready_i = v;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < DRAIN_BOUND; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge rio_phy_clk);
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
    idle_cyc(TIMEOUT + 4);
  endtask

  initial begin
    logic [21:0] tdc;
    bit          hit_seen;

    // reset state
    repeat (3) @(posedge rio_phy_clk);
    #1;
    check_val("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_val("rst_data", out_data_o, 32'd0);
    check_val("rst_lost", {16'd0, lost_windows_o}, 32'd0);
    check_val("rst_drop", {16'd0, dropped_hits_o}, 32'd0);
    rio_phy_rst_n = 1'b1;
    set_ready(1'b1);

    // T1: one window, 5 hits, closed by timeout
    exp_q.push_back(mk_hdr(1'b0, 4'd3, 8'd5));
    for (int i = 1; i <= 5; i++) exp_q.push_back(mk_hit(22'(i)));
    for (int i = 1; i <= 5; i++) drive_rec(4'd3, 22'(i));
    wait_drain("t1_drain");

    // T2: tag change closes window immediately
    exp_q.push_back(mk_hdr(1'b0, 4'd3, 8'd2));
    exp_q.push_back(mk_hit(22'h10));
    exp_q.push_back(mk_hit(22'h11));
    exp_q.push_back(mk_hdr(1'b0, 4'd4, 8'd1));
    exp_q.push_back(mk_hit(22'h20));
    drive_rec(4'd3, 22'h10);
    drive_rec(4'd3, 22'h11);
    drive_rec(4'd4, 22'h20);
    wait_drain("t2_drain");

    // T3: stalled output, 5 single-hit windows, 4 header slots
    set_ready(1'b0);
    for (int t = 1; t <= 4; t++) begin
      exp_q.push_back(mk_hdr(1'b0, 4'(t), 8'd1));
      exp_q.push_back(mk_hit(22'h100 + 22'(t)));
    end
    for (int t = 1; t <= 5; t++) drive_rec(4'(t), 22'h100 + 22'(t));
    idle_cyc(TIMEOUT + 4);
    check_val("t3_lost", {16'd0, lost_windows_o}, 32'd1);
    check_val("t3_drop", {16'd0, dropped_hits_o}, 32'd0);
    check_val("t3_valid_held", {31'd0, out_valid_o}, 32'd1);
    check_val("t3_head_word", out_data_o, mk_hdr(1'b0, 4'd1, 8'd1));
    set_ready(1'b1);
    wait_drain("t3_drain");

    // T4: 300 hits in one window -> count saturates at 255
    exp_q.push_back(mk_hdr(1'b1, 4'd7, 8'd255));
    for (int i = 0; i < 255; i++) exp_q.push_back(mk_hit(22'h100 + 22'(i)));
    for (int i = 0; i < 300; i++) drive_rec(4'd7, 22'h100 + 22'(i));
    wait_drain("t4_drain");
    check_val("t4_drop", {16'd0, dropped_hits_o}, 32'd45);
    check_val("t4_lost", {16'd0, lost_windows_o}, 32'd1);

    // T5: random backpressure during drain
    rand_ready = 1'b1;
    exp_q.push_back(mk_hdr(1'b0, 4'd9, 8'd20));
    for (int i = 0; i < 20; i++) begin
      tdc = 22'($urandom);
      exp_q.push_back(mk_hit(tdc));
      drive_rec(4'd9, tdc);
    end
    wait_drain("t5_drain");
    set_ready(1'b1);

    // T6: reset while draining
    rand_ready = 1'b1;
    exp_q.push_back(mk_hdr(1'b0, 4'hA, 8'd30));
    for (int i = 0; i < 30; i++) begin
      exp_q.push_back(mk_hit(22'h2000 + 22'(i)));
      drive_rec(4'hA, 22'h2000 + 22'(i));
    end
    hit_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge rio_phy_clk);
      if (out_valid_o && !out_data_o[31]) begin
        hit_seen = 1'b1;
        break;
      end
    end
    check_val("t6_reach_drain", {31'd0, hit_seen}, 32'd1);
    #2;
    rio_phy_rst_n = 1'b0;
    rand_ready = 1'b0;
    exp_q.delete();
    @(negedge rio_phy_clk);
    check_val("t6_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_val("t6_rst_data", out_data_o, 32'd0);
    check_val("t6_rst_lost", {16'd0, lost_windows_o}, 32'd0);
    check_val("t6_rst_drop", {16'd0, dropped_hits_o}, 32'd0);
    @(negedge rio_phy_clk);
    rio_phy_rst_n = 1'b1;
    set_ready(1'b1);

    // after reset: tag wrap 15 -> 0 is a plain tag change
    exp_q.push_back(mk_hdr(1'b0, 4'hF, 8'd2));
    exp_q.push_back(mk_hit(22'h3A0001));
    exp_q.push_back(mk_hit(22'h3A0002));
    exp_q.push_back(mk_hdr(1'b0, 4'h0, 8'd3));
    for (int i = 5; i <= 7; i++) exp_q.push_back(mk_hit(22'(i)));
    drive_rec(4'hF, 22'h3A0001);
    drive_rec(4'hF, 22'h3A0002);
    for (int i = 5; i <= 7; i++) drive_rec(4'h0, 22'(i));
    wait_drain("t6_post_drain");
    check_val("t6_post_lost", {16'd0, lost_windows_o}, 32'd0);
    check_val("t6_post_drop", {16'd0, dropped_hits_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
